fmap_bram_writer: RTL and testbench
===================================

Name: fmap_bram_writer

Overview:
- Upstream of the feature-map display tiler: takes one CNN feature map per command as an 8-bit pixel stream and writes it row-major into BRAM port A; the tiler reads port B.
- Tracks per-map min/max; computes contrast gain = (255<<8)/(max-min) with a sequential divider.
- Reports {map_id, min, gain, err} on a one-cycle status pulse, which firmware copies into the tiler's per-map config.

Parameters:
- NM, 22, number of feature maps; map ids >= NM are invalid.
- ADDR_W, 16, BRAM address width.
- DIV_CYC, 16, divider iterations (one quotient bit per cycle).

Ports:
- clk  in  1  single clock for all logic and BRAM port A.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  high in IDLE only.
- cmd_map_id  in  5  target map id.
- cmd_base  in  15  BRAM base address of the map.
- cmd_w  in  6  native width.
- cmd_h  in  6  native height.
- s_tdata  in  8  pixel.
- s_tvalid  in  1  pixel valid.
- s_tready  out  1  high in STREAM only.
- s_tlast  in  1  marks the final pixel of the map.
- bram_we  out  1  port A write enable.
- bram_addr  out  ADDR_W  port A address.
- bram_din  out  8  port A write data.
- busy  out  1  state != IDLE.
- stat_valid  out  1  one-cycle completion pulse.
- stat_map_id  out  5  id of the completed map.
- stat_min  out  8  minimum pixel.
- stat_gain  out  16  contrast gain.
- stat_err  out  1  command or framing error.

Behaviour:
- Reset: the state goes to IDLE. The registered outputs bram_we, bram_addr, bram_din, stat_valid, stat_map_id, stat_min, stat_gain and stat_err reset to 0. cmd_ready, s_tready and busy are decoded from the state. The first cycle after rst deasserts shows cmd_ready=1, s_tready=0, busy=0.
- IDLE:
  - On cmd_valid && cmd_ready, latch the command and clear the counters.
  - Set min=255, max=0, err=0.
  - A command with map_id>=NM, w==0 or h==0 goes to DONE with err=1. No writes occur and no beats are consumed.
  - Otherwise go to STREAM, with total = w*h (12 bits, maximum 3969).
- STREAM:
  - Each beat is s_tvalid && s_tready.
  - Per beat, in the next cycle: bram_we=1, bram_addr = (base + idx) mod 2^ADDR_W, bram_din = s_tdata. Write latency is 1 cycle.
  - bram_we is 0 in every cycle that does not follow a beat.
  - Per beat, update min/max and increment idx.
  - Gaps in s_tvalid are allowed. The address advances only on a beat.
- STREAM exit:
  - If s_tlast arrives on a beat with idx < total-1: set err=1 and go to DIV. That beat is written.
  - If the beat with idx == total-1 has s_tlast=0: set err=1 and still go to DIV. The next beat belongs to the next command.
  - If the final beat has s_tlast=1: go to DIV with err unchanged.
- DIV:
  - range = max - min (8-bit, unsigned; min <= max is guaranteed after at least one beat).
  - If range==0: gain=16'h0100 after 1 cycle.
  - Otherwise: restoring division 65280/range over DIV_CYC cycles; range 1 gives 65280.
  - After division, go to DONE.
- DONE:
  - stat_valid=1 for exactly one cycle.
  - stat_map_id, stat_min, stat_gain and stat_err are updated in that same cycle and hold until the next DONE.
  - Next state is IDLE.
  - For a rejected command: stat_min=0 and stat_gain=0.
- Backpressure: s_tready=0 in IDLE/DIV/DONE, so stream beats are never dropped. cmd_ready=0 outside IDLE.
- Simultaneous events: a cmd_valid arriving in DONE waits for IDLE. It is accepted no earlier than 1 cycle after stat_valid.
- Reset mid-operation (any state):
  - The next state is IDLE and bram_we=0 on the following cycle.
  - No stat_valid is produced for the aborted map. Partially written BRAM contents are left as-is.
- Arithmetic: base+idx uses ADDR_W-bit wrap. Min/max compares are unsigned.

Test Plan:
- Nominal map: cmd id=3, base=0x0100, w=4, h=2; pixels 10,20,…,80 with tlast on the 8th -> 8 writes to 0x0100–0x0107 with matching data; stat_valid once; stat_map_id=3, stat_min=10, stat_gain=65280/70=932, stat_err=0.
- Flat map: w=h=1, pixel 0x55 -> one write; stat_min=0x55, stat_gain=0x0100, err=0.
- Early/late tlast: w=h=2 with tlast on beat 2 -> 2 writes and err=1. Separately, w=h=2 with no tlast -> 4 writes and err=1; a 5th pixel presented afterwards sees s_tready=0 until the next command.
- Invalid command: id=22 (and separately w=0) -> no bram_we, s_tready stays 0, stat_valid with err=1, gain=0.
- Backpressure/wrap and reset: base=0x7FFE, w=4, h=1 with s_tvalid toggling each cycle -> addresses 0x7FFE, 0x7FFF, 0x8000, 0x8001 (no 15-bit wrap), one write per beat. Then rst asserted mid-stream -> bram_we=0 next cycle, no stat_valid, cmd_ready=1 after release.
- Max range: pixels 0 and 255 -> stat_gain=256 and stat_valid exactly DIV_CYC+1 cycles after the last beat's write cycle or later; measure and bound the latency to ≤ DIV_CYC+3.

Source files
------------

// File: rtl/fmap_bram_writer_if.sv
// Command, pixel-stream, BRAM port A and status signals of the feature-map writer.
// The master side is the firmware/stream source; the slave side is the writer.
interface fmap_bram_writer_if #(
   parameter int ADDR_W = 16
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [4:0]        cmd_map_id;
   logic [14:0]       cmd_base;
   logic [5:0]        cmd_w;
   logic [5:0]        cmd_h;
   logic [7:0]        s_tdata;
   logic              s_tvalid;
   logic              s_tready;
   logic              s_tlast;
   logic              bram_we;
   logic [ADDR_W-1:0] bram_addr;
   logic [7:0]        bram_din;
   logic              busy;
   logic              stat_valid;
   logic [4:0]        stat_map_id;
   logic [7:0]        stat_min;
   logic [15:0]       stat_gain;
   logic              stat_err;

   modport master (
      output cmd_valid, cmd_map_id, cmd_base, cmd_w, cmd_h,
      output s_tdata, s_tvalid, s_tlast,
      input  cmd_ready, s_tready, bram_we, bram_addr, bram_din, busy,
      input  stat_valid, stat_map_id, stat_min, stat_gain, stat_err
   );

   modport slave (
      input  cmd_valid, cmd_map_id, cmd_base, cmd_w, cmd_h,
      input  s_tdata, s_tvalid, s_tlast,
      output cmd_ready, s_tready, bram_we, bram_addr, bram_din, busy,
      output stat_valid, stat_map_id, stat_min, stat_gain, stat_err
   );
endinterface

// File: rtl/fmap_bram_writer.sv
// Writes one feature map per command row-major into BRAM port A, tracking min/max,
// then derives the contrast gain (255<<8)/(max-min) with a restoring divider.
module fmap_bram_writer #(
   parameter int NM      = 22,
   parameter int ADDR_W  = 16,
   parameter int DIV_CYC = 16
) (
   input logic               clk,
   input logic               rst,
   fmap_bram_writer_if.slave bus
);
   localparam int CNT_W = $clog2(DIV_CYC + 1);

   typedef enum logic [1:0] {IDLE, STREAM, DIV, DONE} state_t;

   state_t            r_state;
   logic [4:0]        r_map_id;
   logic [14:0]       r_base;
   logic [11:0]       r_total;
   logic [11:0]       r_idx;
   logic [7:0]        r_min;
   logic [7:0]        r_max;
   logic              r_err;
   logic [7:0]        r_divisor;
   logic [7:0]        r_rem;
   logic [15:0]       r_quo;
   logic [CNT_W-1:0]  r_dcnt;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_din;
   logic              r_stat_valid;
   logic [4:0]        r_stat_map_id;
   logic [7:0]        r_stat_min;
   logic [15:0]       r_stat_gain;
   logic              r_stat_err;

   logic              w_cmd_bad;
   logic              w_last_idx;
   logic [7:0]        w_range;
   logic [8:0]        w_shift;
   logic              w_ge;
   logic [7:0]        w_rem_next;
   logic [15:0]       w_quo_next;
   logic              w_div_done;
   logic [15:0]       w_gain;

   assign w_cmd_bad  = ({1'b0, bus.cmd_map_id} >= 6'(NM)) || (bus.cmd_w == 6'd0) || (bus.cmd_h == 6'd0);
   assign w_last_idx = (r_idx == r_total - 12'd1);
   assign w_range    = r_max - r_min;

   // One restoring-division step: the remainder stays below the 8-bit divisor,
   // so a 9-bit shifted value is enough to compare and subtract.
   assign w_shift    = {r_rem, r_quo[15]};
   assign w_ge       = (w_shift >= {1'b0, r_divisor});
   assign w_rem_next = w_ge ? 8'(w_shift - {1'b0, r_divisor}) : w_shift[7:0];
   assign w_quo_next = {r_quo[14:0], w_ge};

   assign w_div_done = (r_dcnt == '0) ? (w_range == 8'd0) : (r_dcnt == CNT_W'(DIV_CYC));
   assign w_gain     = (r_dcnt == '0) ? 16'h0100 : w_quo_next;

   assign bus.cmd_ready   = (r_state == IDLE);
   assign bus.s_tready    = (r_state == STREAM);
   assign bus.busy        = (r_state != IDLE);
   assign bus.bram_we     = r_we;
   assign bus.bram_addr   = r_addr;
   assign bus.bram_din    = r_din;
   assign bus.stat_valid  = r_stat_valid;
   assign bus.stat_map_id = r_stat_map_id;
   assign bus.stat_min    = r_stat_min;
   assign bus.stat_gain   = r_stat_gain;
   assign bus.stat_err    = r_stat_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_map_id      <= '0;
         r_base        <= '0;
         r_total       <= '0;
         r_idx         <= '0;
         r_min         <= '0;
         r_max         <= '0;
         r_err         <= 1'b0;
         r_divisor     <= '0;
         r_rem         <= '0;
         r_quo         <= '0;
         r_dcnt        <= '0;
         r_we          <= 1'b0;
         r_addr        <= '0;
         r_din         <= '0;
         r_stat_valid  <= 1'b0;
         r_stat_map_id <= '0;
         r_stat_min    <= '0;
         r_stat_gain   <= '0;
         r_stat_err    <= 1'b0;
      end else begin
         r_we         <= 1'b0;
         r_stat_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  r_map_id <= bus.cmd_map_id;
                  r_base   <= bus.cmd_base;
                  r_total  <= 12'(bus.cmd_w) * 12'(bus.cmd_h);
                  r_idx    <= '0;
                  r_min    <= 8'hFF;
                  r_max    <= 8'h00;
                  r_err    <= 1'b0;
                  r_dcnt   <= '0;
                  if (w_cmd_bad) begin
                     r_state       <= DONE;
                     r_stat_valid  <= 1'b1;
                     r_stat_map_id <= bus.cmd_map_id;
                     r_stat_min    <= 8'h00;
                     r_stat_gain   <= 16'h0000;
                     r_stat_err    <= 1'b1;
                  end else begin
                     r_state <= STREAM;
                  end
               end
            end
            STREAM: begin
               if (bus.s_tvalid) begin
                  r_we   <= 1'b1;
                  r_addr <= ADDR_W'(r_base) + ADDR_W'(r_idx);
                  r_din  <= bus.s_tdata;
                  r_idx  <= r_idx + 12'd1;
                  if (bus.s_tdata < r_min) r_min <= bus.s_tdata;
                  if (bus.s_tdata > r_max) r_max <= bus.s_tdata;
                  // Either an early tlast or a missing tlast on the final beat ends the map with an error.
                  if (bus.s_tlast || w_last_idx) begin
                     r_state <= DIV;
                     r_dcnt  <= '0;
                     if (!(bus.s_tlast && w_last_idx)) r_err <= 1'b1;
                  end
               end
            end
            DIV: begin
               if (w_div_done) begin
                  r_state       <= DONE;
                  r_stat_valid  <= 1'b1;
                  r_stat_map_id <= r_map_id;
                  r_stat_min    <= r_min;
                  r_stat_gain   <= w_gain;
                  r_stat_err    <= r_err;
               end else if (r_dcnt == '0) begin
                  r_divisor <= w_range;
                  r_rem     <= '0;
                  r_quo     <= 16'hFF00;
                  r_dcnt    <= CNT_W'(1);
               end else begin
                  r_rem  <= w_rem_next;
                  r_quo  <= w_quo_next;
                  r_dcnt <= r_dcnt + CNT_W'(1);
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fmap_bram_writer.sv
// Self-checking bench for fmap_bram_writer: a map-level model predicts every BRAM write
// and status pulse, and a per-cycle monitor compares the DUT against those predictions.
module tb_fmap_bram_writer;
   localparam int DIV_CYC = 16;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_t;

   typedef struct {
      logic [4:0]  id;
      logic [7:0]  mn;
      logic [15:0] gain;
      logic        err;
   } st_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fmap_bram_writer_if #(.ADDR_W(16)) bus ();

   fmap_bram_writer #(.NM(22), .ADDR_W(16), .DIV_CYC(DIV_CYC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   lastWeCyc = 0;
   int   lastLat = 0;
   int   writesSeen = 0;
   logic [15:0] lastWrAddr = '0;
   bit   beatPrev = 1'b0;
   wr_t  expWr[$];
   st_t  expStat[$];
   st_t  lastStat;
   wr_t  wrCur;
   st_t  stCur;
   int   stimPix[$];
   bit   stimLast[$];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // A beat seen at a rising edge must produce exactly one write in the following cycle.
   always @(posedge clk) begin
      cyc      <= cyc + 1;
      beatPrev <= !rst && bus.s_tvalid && bus.s_tready;
   end

   always @(negedge clk) begin
      if (!rst) begin
         checkOutput("we_follows_beat", 32'(bus.bram_we), 32'(beatPrev));
         if (bus.bram_we) begin
            writesSeen++;
            lastWeCyc  = cyc;
            lastWrAddr = bus.bram_addr;
            if (expWr.size() == 0) begin
               checkOutput("unexpected_write", 32'(bus.bram_we), 32'd0);
            end else begin
               wrCur = expWr.pop_front();
               checkOutput("wr_addr", 32'(bus.bram_addr), 32'(wrCur.addr));
               checkOutput("wr_data", 32'(bus.bram_din), 32'(wrCur.data));
            end
         end
         if (bus.stat_valid) begin
            lastLat  = cyc - lastWeCyc;
            lastStat = '{bus.stat_map_id, bus.stat_min, bus.stat_gain, bus.stat_err};
            if (expStat.size() == 0) begin
               checkOutput("unexpected_stat", 32'(bus.stat_valid), 32'd0);
            end else begin
               stCur = expStat.pop_front();
               checkOutput("stat_map_id", 32'(bus.stat_map_id), 32'(stCur.id));
               checkOutput("stat_min", 32'(bus.stat_min), 32'(stCur.mn));
               checkOutput("stat_gain", 32'(bus.stat_gain), 32'(stCur.gain));
               checkOutput("stat_err", 32'(bus.stat_err), 32'(stCur.err));
            end
         end
      end
   end

   // Map-level model: which beats are consumed, where they land, and what status follows.
   task automatic modelMap(input int id, input int base, input int w, input int h, output int consumed);
      int  mn;
      int  mx;
      int  gain;
      int  tot;
      bit  err;
      consumed = 0;
      mn       = 0;
      mx       = 0;
      gain     = 0;
      err      = 1'b1;
      if (id < 22 && w != 0 && h != 0) begin
         tot = w * h;
         mn  = 255;
         for (int k = 0; k < tot; k++) begin
            consumed++;
            expWr.push_back('{16'((base + k) % 65536), 8'(stimPix[k])});
            if (stimPix[k] < mn) mn = stimPix[k];
            if (stimPix[k] > mx) mx = stimPix[k];
            if (stimLast[k] || k == tot - 1) begin
               err = !(stimLast[k] && k == tot - 1);
               break;
            end
         end
         gain = (mx == mn) ? 256 : 65280 / (mx - mn);
      end
      expStat.push_back('{5'(id), 8'(mn), 16'(gain), err});
   endtask

   task automatic driveCmd(input int id, input int base, input int w, input int h);
      bit got;
      got = 1'b0;
      bus.cmd_valid  = 1'b1;
      bus.cmd_map_id = 5'(id);
      bus.cmd_base   = 15'(base);
      bus.cmd_w      = 6'(w);
      bus.cmd_h      = 6'(h);
      for (int n = 0; n < 100 && !got; n++) begin
         got = bus.cmd_ready;
         @(negedge clk);
      end
      bus.cmd_valid = 1'b0;
      checkOutput("cmd_accepted", 32'(got), 32'd1);
   endtask

   task automatic driveBeat(input logic [7:0] d, input bit last);
      bit got;
      got = 1'b0;
      bus.s_tvalid = 1'b1;
      bus.s_tdata  = d;
      bus.s_tlast  = last;
      for (int n = 0; n < 100 && !got; n++) begin
         got = bus.s_tready;
         @(negedge clk);
      end
      bus.s_tvalid = 1'b0;
      bus.s_tlast  = 1'b0;
      checkOutput("beat_accepted", 32'(got), 32'd1);
   endtask

   task automatic waitStat(input bit chkNoReady);
      int n;
      n = 0;
      while (expStat.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
         if (chkNoReady) checkOutput("tready_low", 32'(bus.s_tready), 32'd0);
      end
      if (expStat.size() != 0) begin
         checkOutput("stat_timeout", 32'(expStat.size()), 32'd0);
         expStat.delete();
         expWr.delete();
      end
   endtask

   task automatic applyStimulus(input int id, input int base, input int w, input int h,
                                input int gap, input bit holdExtra);
      int consumed;
      int startWr;
      modelMap(id, base, w, h, consumed);
      startWr = writesSeen;
      if (holdExtra && consumed == 0) begin
         bus.s_tvalid = 1'b1;
         bus.s_tdata  = 8'hEE;
      end
      driveCmd(id, base, w, h);
      checkOutput("busy_after_cmd", 32'(bus.busy), 32'd1);
      for (int k = 0; k < consumed; k++) begin
         driveBeat(8'(stimPix[k]), stimLast[k]);
         repeat (gap) @(negedge clk);
      end
      if (holdExtra) begin
         bus.s_tvalid = 1'b1;
         bus.s_tdata  = 8'hEE;
         bus.s_tlast  = 1'b0;
      end
      waitStat(holdExtra);
      if (holdExtra) begin
         repeat (3) begin
            @(negedge clk);
            checkOutput("tready_low_after", 32'(bus.s_tready), 32'd0);
         end
      end
      bus.s_tvalid = 1'b0;
      @(negedge clk);
      checkOutput("write_count", 32'(writesSeen - startWr), 32'(consumed));
      checkOutput("writes_drained", 32'(expWr.size()), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bus.cmd_valid  = 1'b0;
      bus.cmd_map_id = '0;
      bus.cmd_base   = '0;
      bus.cmd_w      = '0;
      bus.cmd_h      = '0;
      bus.s_tdata    = '0;
      bus.s_tvalid   = 1'b0;
      bus.s_tlast    = 1'b0;

      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      $display("[TB] reset state");
      checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      checkOutput("rst_s_tready", 32'(bus.s_tready), 32'd0);
      checkOutput("rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("rst_bram_we", 32'(bus.bram_we), 32'd0);
      checkOutput("rst_bram_addr", 32'(bus.bram_addr), 32'd0);
      checkOutput("rst_stat_valid", 32'(bus.stat_valid), 32'd0);
      checkOutput("rst_stat_gain", 32'(bus.stat_gain), 32'd0);
      checkOutput("rst_stat_err", 32'(bus.stat_err), 32'd0);

      $display("[TB] nominal map");
      stimPix  = '{10, 20, 30, 40, 50, 60, 70, 80};
      stimLast = '{0, 0, 0, 0, 0, 0, 0, 1};
      applyStimulus(3, 16'h0100, 4, 2, 0, 1'b0);
      checkOutput("nom_id", 32'(lastStat.id), 32'd3);
      checkOutput("nom_min", 32'(lastStat.mn), 32'd10);
      checkOutput("nom_gain", 32'(lastStat.gain), 32'd932);
      checkOutput("nom_err", 32'(lastStat.err), 32'd0);
      checkOutput("nom_last_addr", 32'(lastWrAddr), 32'h0107);

      $display("[TB] flat map");
      stimPix  = '{8'h55};
      stimLast = '{1};
      applyStimulus(5, 16'h0200, 1, 1, 0, 1'b0);
      checkOutput("flat_min", 32'(lastStat.mn), 32'h55);
      checkOutput("flat_gain", 32'(lastStat.gain), 32'h0100);
      checkOutput("flat_err", 32'(lastStat.err), 32'd0);

      $display("[TB] early tlast");
      stimPix  = '{40, 30, 90, 99};
      stimLast = '{0, 1, 0, 0};
      applyStimulus(1, 16'h0300, 2, 2, 0, 1'b0);
      checkOutput("early_err", 32'(lastStat.err), 32'd1);
      checkOutput("early_gain", 32'(lastStat.gain), 32'd6528);

      $display("[TB] missing tlast with a trailing pixel");
      stimPix  = '{5, 6, 7, 8};
      stimLast = '{0, 0, 0, 0};
      applyStimulus(2, 16'h0400, 2, 2, 0, 1'b1);
      checkOutput("late_err", 32'(lastStat.err), 32'd1);
      checkOutput("late_min", 32'(lastStat.mn), 32'd5);

      $display("[TB] invalid commands");
      stimPix  = '{1, 2, 3, 4};
      stimLast = '{0, 0, 0, 1};
      applyStimulus(22, 16'h0500, 2, 2, 0, 1'b1);
      checkOutput("bad_id_err", 32'(lastStat.err), 32'd1);
      checkOutput("bad_id_gain", 32'(lastStat.gain), 32'd0);
      checkOutput("bad_id_map", 32'(lastStat.id), 32'd22);
      applyStimulus(4, 16'h0500, 0, 3, 0, 1'b1);
      checkOutput("bad_w_err", 32'(lastStat.err), 32'd1);
      checkOutput("bad_w_min", 32'(lastStat.mn), 32'd0);

      $display("[TB] gapped stream across 0x7FFF");
      stimPix  = '{100, 50, 200, 150};
      stimLast = '{0, 0, 0, 1};
      applyStimulus(6, 16'h7FFE, 4, 1, 1, 1'b0);
      checkOutput("wrap_last_addr", 32'(lastWrAddr), 32'h8001);
      checkOutput("wrap_gain", 32'(lastStat.gain), 32'd435);
      checkOutput("wrap_min", 32'(lastStat.mn), 32'd50);

      $display("[TB] reset mid-stream");
      expWr.push_back('{16'h0600, 8'd11});
      expWr.push_back('{16'h0601, 8'd22});
      driveCmd(7, 16'h0600, 4, 1);
      driveBeat(8'd11, 1'b0);
      driveBeat(8'd22, 1'b0);
      #1 rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst_we", 32'(bus.bram_we), 32'd0);
      checkOutput("midrst_stat", 32'(bus.stat_valid), 32'd0);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
      repeat (25) @(negedge clk);
      checkOutput("midrst_writes_drained", 32'(expWr.size()), 32'd0);

      $display("[TB] full range");
      stimPix  = '{0, 255};
      stimLast = '{0, 1};
      applyStimulus(8, 16'h0700, 2, 1, 0, 1'b0);
      checkOutput("max_gain", 32'(lastStat.gain), 32'd256);
      checkOutput("max_lat_lo", 32'(lastLat >= DIV_CYC + 1), 32'd1);
      checkOutput("max_lat_hi", 32'(lastLat <= DIV_CYC + 3), 32'd1);

      $display("[TB] unit range");
      stimPix  = '{7, 8};
      stimLast = '{0, 1};
      applyStimulus(9, 16'h0800, 1, 2, 0, 1'b0);
      checkOutput("one_gain", 32'(lastStat.gain), 32'd65280);

      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
